// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter: data has priority, inst gets a forced
// grant after STARVE_MAX consecutive data grants. One transaction in flight.
module sram_like_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    RESP
  } state_e;

  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

  logic sel_data;
  logic req_act;
  logic grant;
  logic force_inst;
  logic win_data;
  logic win_inst;
  logic inst_aok, data_aok;
  logic inst_dok, data_dok;

  assign force_inst = inst_req && (starve_cnt_q == SMAX);
  assign win_data   = data_req && !force_inst;
  assign win_inst   = inst_req && !win_data;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    starve_cnt_d = starve_cnt_q;
    sel_data     = owner_q;
    req_act      = 1'b0;
    grant        = 1'b0;
    inst_aok     = 1'b0;
    data_aok     = 1'b0;
    inst_dok     = 1'b0;
    data_dok     = 1'b0;

    unique case (state_q)
      IDLE: begin
        sel_data = win_data;
        req_act  = win_data || win_inst;
        if (req_act) begin
          owner_d = win_data;
          grant   = mem_addr_ok;
          state_d = mem_addr_ok ? RESP : HOLD;
        end
      end
      HOLD: begin
        req_act = owner_q ? data_req : inst_req;
        // owner withdrew its request: abandon without touching the counter
        if (!req_act) begin
          state_d = IDLE;
        end else if (mem_addr_ok) begin
          grant   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        data_dok = owner_q && mem_data_ok;
        inst_dok = !owner_q && mem_data_ok;
        if (mem_data_ok) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      data_aok = sel_data;
      inst_aok = !sel_data;
      if (sel_data && inst_req) begin
        if (starve_cnt_q < SMAX) starve_cnt_d = starve_cnt_q + 1'b1;
      end else begin
        starve_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // handshake outputs are gated so reset silences them without a clock
  assign mem_req      = resetn && req_act;
  assign inst_addr_ok = resetn && inst_aok;
  assign data_addr_ok = resetn && data_aok;
  assign inst_data_ok = resetn && inst_dok;
  assign data_data_ok = resetn && data_dok;

  assign mem_wr    = sel_data ? data_wr    : inst_wr;
  assign mem_size  = sel_data ? data_size  : inst_size;
  assign mem_wstrb = sel_data ? data_wstrb : inst_wstrb;
  assign mem_addr  = sel_data ? data_addr  : inst_addr;
  assign mem_wdata = sel_data ? data_wdata : inst_wdata;

  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Scoreboard bench for sram_like_arbiter: grants push expected responses,
// response cycles pop and check routing and read data.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr;
  logic [1:0]  inst_size;
  logic [3:0]  inst_wstrb;
  logic [31:0] inst_addr, inst_wdata;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          who;
    logic [31:0] rd;
  } exp_t;

  exp_t sb[$];

  localparam logic [31:0] IA = 32'h1c00_0000;
  localparam logic [31:0] DA = 32'h1c00_0100;

  sram_like_arbiter #(.STARVE_MAX(4), .CNT_W(4)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_wstrb(inst_wstrb), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // who: 1=data, 0=inst. waits = cycles of mem_addr_ok=0 before grant.
  task automatic xact(input bit who, input int waits,
                      input logic [31:0] rd, input logic [31:0] ea,
                      input logic ewr, input logic [3:0] estrb);
    exp_t e;
    for (int i = 0; i <= waits; i++) begin
      @(negedge clk);
      mem_addr_ok = (i == waits);
      #1;
      chk("mem_req", 32'(mem_req), 32'd1);
      chk("mem_addr", mem_addr, ea);
      chk("win_aok", 32'(who ? data_addr_ok : inst_addr_ok),
          32'(i == waits));
      chk("lose_aok", 32'(who ? inst_addr_ok : data_addr_ok), 32'd0);
    end
    chk("mem_wr", 32'(mem_wr), 32'(ewr));
    chk("mem_wstrb", 32'(mem_wstrb), 32'(estrb));
    e.who = who;
    e.rd  = rd;
    sb.push_back(e);
    @(negedge clk);
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    #1;
    chk("resp_req", 32'(mem_req), 32'd0);
    chk("resp_aok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk("own_dok", 32'(e.who ? data_data_ok : inst_data_ok), 32'd1);
      chk("oth_dok", 32'(e.who ? inst_data_ok : data_data_ok), 32'd0);
      chk("rdata", e.who ? data_rdata : inst_rdata, e.rd);
    end
    @(posedge clk);
    #1;
    mem_data_ok = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    {inst_req, inst_wr, inst_size, inst_wstrb} = '0;
    {data_req, data_wr, data_size, data_wstrb} = '0;
    inst_addr = IA; inst_wdata = 32'h0;
    data_addr = DA; data_wdata = 32'h0;
    inst_size = 2'd2; data_size = 2'd2;
    {mem_addr_ok, mem_data_ok} = '0;
    mem_rdata = '0;

    // requests present while in reset must not reach the slave
    inst_req = 1'b1; data_req = 1'b1; mem_addr_ok = 1'b1;
    #12;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_aok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    chk("rst_cnt", 32'(dut.starve_cnt_q), 32'd0);
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // stray data_ok in IDLE
    @(negedge clk);
    mem_data_ok = 1'b1;
    #1;
    chk("stray_dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    chk("idle_req", 32'(mem_req), 32'd0);
    @(posedge clk); #1;
    mem_data_ok = 1'b0;

    // data read alone
    data_req = 1'b1;
    xact(1'b1, 0, 32'hdeadbeef, DA, 1'b0, 4'h0);
    chk("cnt_alone", 32'(dut.starve_cnt_q), 32'd0);

    // contention: data first, then inst
    inst_req = 1'b1;
    xact(1'b1, 0, 32'h1111_0001, DA, 1'b0, 4'h0);
    chk("cnt_cont", 32'(dut.starve_cnt_q), 32'd1);
    data_req = 1'b0;
    xact(1'b0, 0, 32'h2222_0002, IA, 1'b0, 4'h0);
    chk("cnt_clr", 32'(dut.starve_cnt_q), 32'd0);

    // starvation: four data grants, fifth forced to inst
    data_req = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      xact(1'b1, 0, 32'h3300_0000 + k, DA, 1'b0, 4'h0);
      chk("cnt_starve", 32'(dut.starve_cnt_q), k);
    end
    xact(1'b0, 0, 32'h4444_0004, IA, 1'b0, 4'h0);
    chk("cnt_forced", 32'(dut.starve_cnt_q), 32'd0);

    // slave back-pressure: data held 3 cycles, inst locked out
    xact(1'b1, 3, 32'h5555_0005, DA, 1'b0, 4'h0);
    chk("cnt_bp", 32'(dut.starve_cnt_q), 32'd1);
    data_req = 1'b0;
    xact(1'b0, 0, 32'h6666_0006, IA, 1'b0, 4'h0);
    inst_req = 1'b0;

    // data write routing
    data_req = 1'b1; data_wr = 1'b1;
    data_size = 2'd1; data_wstrb = 4'b0011;
    xact(1'b1, 0, 32'h0, DA, 1'b1, 4'b0011);
    data_req = 1'b0; data_wr = 1'b0;
    data_size = 2'd2; data_wstrb = 4'h0;

    // owner drops request in HOLD, then stray data_ok is ignored
    data_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    data_req = 1'b0;
    mem_data_ok = 1'b1;
    #1;
    chk("hold_drop", 32'(mem_req), 32'd0);
    chk("hold_dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    @(posedge clk); #1;
    mem_data_ok = 1'b0;
    inst_req = 1'b1;
    xact(1'b0, 0, 32'h7777_0007, IA, 1'b0, 4'h0);
    inst_req = 1'b0;

    // async reset while in RESP
    data_req = 1'b1;
    @(negedge clk);
    mem_addr_ok = 1'b1;
    @(posedge clk); #1;
    mem_addr_ok = 1'b0;
    @(negedge clk);
    mem_data_ok = 1'b1;
    mem_rdata = 32'hbad0_0bad;
    #1;
    resetn = 1'b0;
    #1;
    chk("ar_req", 32'(mem_req), 32'd0);
    chk("ar_dok", 32'({inst_data_ok, data_data_ok}), 32'd0);
    chk("ar_aok", 32'({inst_addr_ok, data_addr_ok}), 32'd0);
    data_req = 1'b0;
    mem_data_ok = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    inst_req = 1'b1;
    xact(1'b0, 0, 32'h8888_0008, IA, 1'b0, 4'h0);
    inst_req = 1'b0;

    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
